mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//   Arbitrates one shared single-port memory between an instruction-fetch
//   port and a data (load/store) port. The data port normally wins, but a
//   waiting fetch is guaranteed a grant after STARVE_MAX consecutive data
//   grants. Each access holds the memory for MEM_LAT cycles, then reports
//   completion with a one-cycle ready pulse.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   if_req/if_addr              fetch request and word address
//   if_ready/if_rdata           fetch completion pulse and fetched word
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_ready/d_rdata             data completion pulse and loaded word
//   addr_err                    pulses with ready when the address was >= DEPTH
//   mon_update                  pulses with d_ready for a store into the monitor region
//   mem_addr/mem_write_data/mem_MemWrite/mem_read_data   memory side
module mem_arbiter #(
    parameter int DEPTH      = 512,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4,
    parameter int MON_BASE   = 495
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        addr_err,
    output logic        mon_update,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_read_data
);

    localparam logic [1:0]  LAT_LAST   = 2'(MEM_LAT - 1);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
    localparam logic [31:0] MON_LO     = 32'(MON_BASE);
    localparam logic [31:0] MON_HI     = 32'(MON_BASE + 15);

    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lat_cnt;
    logic [3:0]  starve_cnt;

    // Access latched at grant time so a dropped request still completes.
    logic        g_is_d;
    logic        g_we;
    logic        g_oob;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;

    logic        pick_if, pick_d;
    logic [31:0] sel_addr;
    logic        lat_last;

    // Data wins ties unless the fetch port has been passed over STARVE_MAX times.
    always_comb begin
        pick_if  = if_req && (!d_req || (starve_cnt == STARVE_LIM));
        pick_d   = d_req && !pick_if;
        sel_addr = pick_if ? if_addr : d_addr;
        lat_last = (lat_cnt == LAT_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_if)     state_nxt = ACC_IF;
                else if (pick_d) state_nxt = ACC_D;
            end
            ACC_IF, ACC_D: begin
                if (lat_last) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, latency/starvation counters and read-data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt    <= '0;
            starve_cnt <= '0;
            g_is_d     <= 1'b0;
            g_we       <= 1'b0;
            g_oob      <= 1'b0;
            g_addr     <= '0;
            g_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (pick_if || pick_d) begin
                        g_is_d  <= pick_d;
                        g_we    <= pick_d && d_we;
                        g_oob   <= (sel_addr >= DEPTH_W);
                        g_addr  <= sel_addr;
                        g_wdata <= d_wdata;
                    end
                    if (pick_if)
                        starve_cnt <= '0;
                    else if (pick_d && if_req && (starve_cnt != STARVE_LIM))
                        starve_cnt <= starve_cnt + 4'd1;
                end
                ACC_IF, ACC_D: begin
                    if (lat_last) begin
                        lat_cnt <= '0;
                        if (!g_is_d)
                            if_rdata <= g_oob ? '0 : mem_read_data;
                        else if (!g_we)
                            d_rdata <= g_oob ? '0 : mem_read_data;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: lat_cnt <= '0;
            endcase
        end
    end

    // Output logic
    always_comb begin
        if_ready       = 1'b0;
        d_ready        = 1'b0;
        addr_err       = 1'b0;
        mon_update     = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_MemWrite   = 1'b0;
        case (state)
            ACC_IF: begin
                mem_addr = g_oob ? '0 : g_addr;
            end
            ACC_D: begin
                mem_addr       = g_oob ? '0 : g_addr;
                mem_write_data = g_we ? g_wdata : '0;
                // Write only in the first cycle so a multi-cycle access stores once.
                mem_MemWrite   = g_we && !g_oob && (lat_cnt == '0);
            end
            RESP: begin
                if_ready   = !g_is_d;
                d_ready    = g_is_d;
                addr_err   = g_oob;
                mon_update = g_is_d && g_we && !g_oob &&
                             (g_addr >= MON_LO) && (g_addr <= MON_HI);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: MEM_LAT=1, instance 1: MEM_LAT=3
    logic [1:0]        rst, if_req, d_req, d_we;
    logic [1:0][31:0]  if_addr, d_addr, d_wdata, mem_rd;
    logic [1:0]        if_ready, d_ready, addr_err, mon_upd, mem_we;
    logic [1:0][31:0]  if_rdata, d_rdata, mem_addr, mem_wd;

    logic [31:0] mem     [2][DEPTH];
    logic [31:0] ref_mem [2][DEPTH];
    int          starve_m [2];

    logic        pl_en = 1'b0;
    int          pl_k  = 0;
    logic [8:0]  pl_a  = '0;
    logic [31:0] pl_d  = '0;

    int total = 0;
    int bad   = 0;
    int wr_cnt [2] = '{0, 0};
    int both_viol = 0;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            mem_arbiter #(
                .DEPTH(DEPTH), .MEM_LAT(g == 0 ? 1 : 3),
                .STARVE_MAX(4), .MON_BASE(495)
            ) u_dut (
                .clk(clk), .reset(rst[g]),
                .if_req(if_req[g]), .if_addr(if_addr[g]),
                .if_ready(if_ready[g]), .if_rdata(if_rdata[g]),
                .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]),
                .d_wdata(d_wdata[g]), .d_ready(d_ready[g]), .d_rdata(d_rdata[g]),
                .addr_err(addr_err[g]), .mon_update(mon_upd[g]),
                .mem_addr(mem_addr[g]), .mem_write_data(mem_wd[g]),
                .mem_MemWrite(mem_we[g]), .mem_read_data(mem_rd[g])
            );
            assign mem_rd[g] = mem[g][mem_addr[g][8:0]];
        end
    endgenerate

    // Memory model: combinational read, write on rising edge
    always @(posedge clk) begin
        if (pl_en) mem[pl_k][pl_a] <= pl_d;
        for (int k = 0; k < 2; k++)
            if (mem_we[k]) mem[k][mem_addr[k][8:0]] <= mem_wd[k];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (if_ready[k] && d_ready[k]) both_viol++;
            wr_cnt[k] += int'(mem_we[k]);
        end
    endtask

    task automatic preload(input int k, input int a, input logic [31:0] d);
        pl_en = 1'b1; pl_k = k; pl_a = 9'(a); pl_d = d;
        tick();
        pl_en = 1'b0;
        ref_mem[k][a] = d;
    endtask

    // One isolated request; expectations derived from the access rules.
    task automatic txn(input int k, input bit is_if, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag);
        int lat, n, w0;
        bit got, oob, mon;
        logic [31:0] exp_d, exp_i;
        lat   = (k == 0) ? 1 : 3;
        oob   = (addr >= 32'(DEPTH));
        mon   = !is_if && we && !oob && (addr >= 32'd495) && (addr <= 32'd510);
        exp_d = d_rdata[k];
        exp_i = if_rdata[k];
        w0    = wr_cnt[k];
        if (is_if) begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end else begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
        end
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            tick(); n++;
            got = is_if ? if_ready[k] : d_ready[k];
        end
        chk({tag, " latency"}, 32'(n), 32'(lat + 1));
        chk({tag, " addr_err"}, 32'(addr_err[k]), 32'(oob));
        chk({tag, " mon_update"}, 32'(mon_upd[k]), 32'(mon));
        chk({tag, " writes"}, 32'(wr_cnt[k] - w0), (!is_if && we && !oob) ? 32'd1 : 32'd0);
        if (is_if) begin
            exp_i = oob ? '0 : ref_mem[k][addr[8:0]];
            starve_m[k] = 0;
        end else if (!we) begin
            exp_d = oob ? '0 : ref_mem[k][addr[8:0]];
        end
        chk({tag, " if_rdata"}, if_rdata[k], exp_i);
        chk({tag, " d_rdata"}, d_rdata[k], exp_d);
        if (!is_if && we && !oob) ref_mem[k][addr[8:0]] = wd;
        if_req[k] = 1'b0; d_req[k] = 1'b0;
        tick();
        chk({tag, " ready pulse width"}, 32'(if_ready[k] | d_ready[k]), 32'd0);
    endtask

    // Requests held continuously; checks grant order, spacing and data.
    task automatic stream(input int k, input bit with_if, input int n_done, input string tag);
        int lat, cyc, done, last;
        bit exp_if, cur_we;
        logic [31:0] cur_ia, cur_da, cur_wd;
        lat = (k == 0) ? 1 : 3;
        cur_ia = 32'($urandom_range(0, 494));
        cur_da = 32'($urandom_range(0, 494));
        cur_we = 1'($urandom_range(0, 1));
        cur_wd = $urandom;
        if_req[k] = with_if; if_addr[k] = cur_ia;
        d_req[k] = 1'b1; d_we[k] = cur_we; d_addr[k] = cur_da; d_wdata[k] = cur_wd;
        cyc = 0; done = 0; last = -1;
        while (done < n_done && cyc < 400) begin
            tick(); cyc++;
            if (if_ready[k] || d_ready[k]) begin
                exp_if = with_if && (starve_m[k] == 4);
                chk($sformatf("%s grant%0d is_fetch", tag, done), 32'(if_ready[k]), 32'(exp_if));
                if (last >= 0)
                    chk($sformatf("%s spacing%0d", tag, done), 32'(cyc - last), 32'(lat + 2));
                last = cyc;
                if (if_ready[k]) begin
                    chk($sformatf("%s fetch%0d data", tag, done), if_rdata[k], ref_mem[k][cur_ia[8:0]]);
                    starve_m[k] = 0;
                    cur_ia = 32'($urandom_range(0, 494));
                    if_addr[k] = cur_ia;
                end else begin
                    if (cur_we) ref_mem[k][cur_da[8:0]] = cur_wd;
                    else chk($sformatf("%s load%0d data", tag, done), d_rdata[k], ref_mem[k][cur_da[8:0]]);
                    if (with_if && starve_m[k] < 4) starve_m[k]++;
                    cur_da = 32'($urandom_range(0, 494));
                    cur_we = 1'($urandom_range(0, 1));
                    cur_wd = $urandom;
                    d_we[k] = cur_we; d_addr[k] = cur_da; d_wdata[k] = cur_wd;
                end
                done++;
            end
        end
        chk({tag, " completions"}, 32'(done), 32'(n_done));
        if_req[k] = 1'b0; d_req[k] = 1'b0;
        tick(); tick();
    endtask

    initial begin
        int k, rdy, mism;
        bit is_if, we;
        logic [31:0] a, old300;

        rst = '1; if_req = '0; d_req = '0; d_we = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        starve_m = '{0, 0};
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d outputs", i),
                32'({if_ready[i], d_ready[i], addr_err[i], mon_upd[i], mem_we[i]}), 32'd0);
            chk($sformatf("reset%0d mem_addr", i), mem_addr[i], 32'd0);
            chk($sformatf("reset%0d rdata", i), if_rdata[i] | d_rdata[i], 32'd0);
        end
        rst = '0;
        tick();

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++) preload(i, j, $urandom);
        preload(0, 128, 32'h8c030000);

        // Directed scenarios on MEM_LAT=1
        txn(0, 1'b1, 1'b0, 32'd128, 32'd0, "fetch128");
        chk("fetch128 word", if_rdata[0], 32'h8c030000);
        txn(0, 1'b0, 1'b1, 32'd496, 32'd41, "store496");
        txn(0, 1'b0, 1'b0, 32'd496, 32'd0, "load496");
        chk("load496 word", d_rdata[0], 32'd41);
        stream(0, 1'b1, 10, "starve");
        txn(0, 1'b0, 1'b1, 32'd600, 32'hdeadbeef, "oob_store");
        chk("oob_store alias word", mem[0][88], ref_mem[0][88]);
        txn(0, 1'b0, 1'b0, 32'd600, 32'd0, "oob_load");
        txn(0, 1'b1, 1'b0, 32'd1000, 32'd0, "oob_fetch");

        // MEM_LAT=3
        txn(1, 1'b0, 1'b0, 32'd100, 32'd0, "lat3_load");
        stream(1, 1'b0, 4, "lat3_b2b");

        // Reset in the write cycle of a store on MEM_LAT=1
        txn(0, 1'b0, 1'b0, 32'd7, 32'd0, "pre_reset_load");
        old300 = ref_mem[0][300];
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd300; d_wdata[0] = ~old300;
        tick();
        chk("rst_mid write cycle reached", 32'(mem_we[0]), 32'd1);
        #1 rst[0] = 1'b1;
        #1;
        chk("rst_mid mem_we", 32'(mem_we[0]), 32'd0);
        chk("rst_mid mem_addr", mem_addr[0], 32'd0);
        chk("rst_mid rdata", if_rdata[0] | d_rdata[0], 32'd0);
        d_req[0] = 1'b0;
        tick();
        rst[0] = 1'b0;
        starve_m[0] = 0;
        rdy = 0;
        repeat (4) begin
            tick();
            rdy += int'(d_ready[0] | if_ready[0]);
        end
        chk("rst_mid no ready", 32'(rdy), 32'd0);
        chk("rst_mid word unchanged", mem[0][300], old300);

        // Random isolated traffic on both instances
        for (int i = 0; i < 60; i++) begin
            k     = int'($urandom_range(0, 1));
            is_if = ($urandom_range(0, 2) == 0);
            we    = !is_if && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0)      a = 32'($urandom_range(512, 1023));
            else if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(490, 511));
            else                                a = 32'($urandom_range(0, 511));
            txn(k, is_if, we, a, $urandom, $sformatf("rnd%0d", i));
        end

        mism = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++)
                if (mem[i][j] !== ref_mem[i][j]) mism++;
        chk("final memory image", 32'(mism), 32'd0);
        chk("ready exclusivity", 32'(both_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
